// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared types and defaults for the shared "1011" detector.
// It holds the controller state enum, the detector state enum and the
// default requester count and word width.
package seq_det_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    FLUSH = 2'b10,
    DONE  = 2'b11
  } ctrl_state_t;

  typedef enum logic [2:0] {
    A = 3'b000,
    B = 3'b001,
    C = 3'b010,
    D = 3'b011,
    E = 3'b100
  } det_state_t;

endpackage

// File: rtl/seq_det_core.sv
// seq_det_core: 5-state Moore recogniser for the bit pattern "1011".
// det is high while the state is E, so a detection shows up one cycle
// after the bit that completes the pattern.
// Build option: SEQ_DET_OVERLAP_EN selects overlapping detection
// (E,0->C). Without it the recogniser restarts after a hit (E,0->A).
module seq_det_core
  import seq_det_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  input  logic x,
  output logic det
);

  det_state_t st;

  function automatic det_state_t next_st(input det_state_t s, input logic b);
    det_state_t n;
    case (s)
      A:       n = b ? B : A;
      B:       n = b ? B : C;
      C:       n = b ? D : A;
      D:       n = b ? E : C;
`ifdef SEQ_DET_OVERLAP_EN
      E:       n = b ? B : C;
`else
      E:       n = b ? B : A;
`endif
      default: n = A;
    endcase
    return n;
  endfunction

  // Recogniser state: clr restarts at A, en advances by one bit, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= A;
    end else if (clr) begin
      st <= A;
    end else if (en) begin
      st <= next_st(st, x);
    end
  end

  assign det = (st == E);

endmodule

// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin scheduler that lets NREQ requesters share a
// single "1011" detector. The granted word is shifted MSB first through
// seq_det_core. The number of detections is reported with a done pulse
// WIDTH+1 cycles after the one-hot grant pulse.
// Build option: SEQ_DET_OVERLAP_EN (passed to seq_det_core) selects
// overlapping detection.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter  int NREQ  = NREQ_DEF,
  parameter  int WIDTH = WIDTH_DEF,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW    = $clog2(WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [CW-1:0]         match_cnt
);

  ctrl_state_t      state;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             grant_fire;
  logic [WIDTH-1:0] sel_word;
  logic [WIDTH-1:0] word;
  logic [CW-1:0]    bitcnt;
  logic [CW-1:0]    acc;
  logic             det;

  // Round-robin pick: scan upward from the requester after last_grant.
  always_comb begin : rr_pick
    int             idx;
    logic [IDW-1:0] cand;
    idx    = 0;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = idx[IDW-1:0];
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Route the winning requester's word to the load port of the shift register.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == IDW'(i)) sel_word = data[i*WIDTH +: WIDTH];
    end
  end

  // A grant can be taken from IDLE and also from DONE. DONE counts as the
  // idle point of a back-to-back run, so a single requester that keeps its
  // request up is served every WIDTH+2 cycles and loses no extra cycle.
  assign grant_fire = found && ((state == IDLE) || (state == DONE));

  // Word register: load at the grant edge and shift left once per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (grant_fire) begin
      word <= sel_word;
    end else if (state == SHIFT) begin
      word <= word << 1;
    end
  end

  seq_det_core u_core (
    .clk (clk),
    .rst (rst),
    .clr (grant_fire),
    .en  (state == SHIFT),
    .x   (word[WIDTH-1]),
    .det (det)
  );

  // Controller FSM with registered gnt/busy/done and result outputs.
  // acc counts cycles in which det is high during SHIFT and FLUSH. In the
  // first SHIFT cycle det is always low because the recogniser was just
  // cleared. The hit on the final bit is only visible in FLUSH, so that
  // hit is added when the result is latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= '0;
      match_cnt  <= '0;
      last_grant <= IDW'(NREQ - 1);
      bitcnt     <= '0;
      acc        <= '0;
    end else begin
      gnt  <= '0;
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (grant_fire) begin
            state      <= SHIFT;
            gnt        <= NREQ'(1) << winner;
            busy       <= 1'b1;
            last_grant <= winner;
            bitcnt     <= '0;
            acc        <= '0;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          acc    <= acc + CW'(det);
          bitcnt <= bitcnt + 1'b1;
          if (bitcnt == CW'(WIDTH - 1)) state <= FLUSH;
        end
        FLUSH: begin
          state     <= DONE;
          done      <= 1'b1;
          done_id   <= last_grant;
          match_cnt <= acc + CW'(det);
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_sched.sv
// tb_seq_det_sched: table-driven and scoreboard-checked bench for seq_det_sched.
module tb_seq_det_sched;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int CW    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] data;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  done;
  logic [IDW-1:0]        done_id;
  logic [CW-1:0]         match_cnt;

  seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_id   (done_id),
    .match_cnt (match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDW-1:0] id;
    logic [CW-1:0]  cnt;
  } exp_t;

  typedef struct {
    int         id;
    logic [7:0] word;
    int         cnt_ovl;
    int         cnt_nov;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference recogniser: 0..4 stand for A..E. Hits are counted after each bit.
  function automatic int model_cnt(input logic [7:0] w);
    int st = 0;
    int n  = 0;
    for (int i = 7; i >= 0; i--) begin
      case (st)
        0: st = w[i] ? 1 : 0;
        1: st = w[i] ? 1 : 2;
        2: st = w[i] ? 3 : 0;
        3: st = w[i] ? 4 : 2;
`ifdef SEQ_DET_OVERLAP_EN
        default: st = w[i] ? 1 : 2;
`else
        default: st = w[i] ? 1 : 0;
`endif
      endcase
      if (st == 4) n++;
    end
    return n;
  endfunction

  function automatic logic [NREQ*WIDTH-1:0] pack4(input logic [7:0] w0, input logic [7:0] w1,
                                                  input logic [7:0] w2, input logic [7:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  task automatic push_exp(input int id, input int cnt);
    exp_t e;
    e.id  = id[IDW-1:0];
    e.cnt = cnt[CW-1:0];
    sbq.push_back(e);
  endtask

  task automatic wait_gnt(output int idx);
    bit seen;
    idx  = -1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (gnt != '0) begin
        seen = 1'b1;
        for (int b = 0; b < NREQ; b++) if (gnt[b]) idx = b;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout actual=none required=grant");
    end
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 40 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL %s_idle_timeout actual=busy required=idle", tag);
    end
  endtask

  // Drive one requester with one word, let the word finish, then check that the result holds.
  task automatic run_word(input int id, input logic [7:0] w, input int exp_cnt, input string tag);
    int gi;
    logic [7:0] ws[4];
    @(negedge clk);
    for (int i = 0; i < 4; i++) ws[i] = (i == id) ? w : 8'h00;
    data = pack4(ws[0], ws[1], ws[2], ws[3]);
    req  = 4'(1 << id);
    push_exp(id, exp_cnt);
    wait_gnt(gi);
    chk({tag, "_gnt_id"}, gi, id);
    req  = '0;
    data = ~data;
    wait_idle(tag);
    repeat (2) @(negedge clk);
    chk({tag, "_hold_cnt"}, match_cnt, exp_cnt);
    chk({tag, "_hold_id"}, done_id, id);
  endtask

  // Scoreboard consumer: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=id%0d/cnt%0d required=none", done_id, match_cnt);
      end else begin
        e = sbq.pop_front();
        chk("done_id", done_id, e.id);
        chk("match_cnt", match_cnt, e.cnt);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    vec_t       tbl[7];
    logic [7:0] rw[4];
    int         gi;
    int         nxt;

    tbl[0] = '{0, 8'hB6, 2, 1};
    tbl[1] = '{2, 8'hBB, 2, 2};
    tbl[2] = '{2, 8'hFF, 0, 0};
    tbl[3] = '{3, 8'h00, 0, 0};
    tbl[4] = '{1, 8'h0B, 1, 1};
    tbl[5] = '{0, 8'hB0, 1, 1};
    tbl[6] = '{1, 8'h5B, 2, 1};

    rst  = 1'b1;
    req  = '0;
    data = '0;
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_done_id", done_id, 0);
    chk("rst_match_cnt", match_cnt, 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
`ifdef SEQ_DET_OVERLAP_EN
      run_word(tbl[i].id, tbl[i].word, tbl[i].cnt_ovl, "tbl");
`else
      run_word(tbl[i].id, tbl[i].word, tbl[i].cnt_nov, "tbl");
`endif
    end

    for (int i = 0; i < 10; i++) begin
      logic [7:0] w;
      int id;
      w  = 8'($urandom);
      id = int'($urandom_range(0, 3));
      run_word(id, w, model_cnt(w), "rnd");
    end

    // Round robin with all four requesters held, after a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    rw[0] = 8'hB6; rw[1] = 8'hBB; rw[2] = 8'hFF; rw[3] = 8'h0B;
    data = pack4(rw[0], rw[1], rw[2], rw[3]);
    req  = 4'b1111;
    wait_gnt(gi);
    chk("rr_first", gi, 0);
    push_exp(0, model_cnt(rw[0]));
    for (int k = 1; k <= 4; k++) begin
      for (int j = 1; j <= 9; j++) begin
        @(negedge clk);
        chk("rr_busy", busy, 1);
        chk("rr_done_slot", done, (j == 9) ? 1 : 0);
        chk("rr_no_gnt", gnt, 0);
      end
      @(negedge clk);
      nxt = k % 4;
      chk("rr_gnt", gnt, 1 << nxt);
      push_exp(nxt, model_cnt(rw[nxt]));
      if (k == 4) req = '0;
    end
    wait_idle("rr");

    // Reset in the 4th SHIFT cycle aborts the word. After release, req[0] wins first.
    @(negedge clk);
    rw[0] = 8'hBB; rw[1] = 8'hB6; rw[2] = 8'h00; rw[3] = 8'h00;
    data = pack4(rw[0], rw[1], rw[2], rw[3]);
    req  = 4'b0010;
    wait_gnt(gi);
    chk("abort_gnt", gi, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_gnt_zero", gnt, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_done_id", done_id, 0);
    chk("abort_match_cnt", match_cnt, 0);
    req = 4'b0011;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_exp(0, model_cnt(rw[0]));
    wait_gnt(gi);
    chk("post_rst_gnt", gi, 0);
    req = '0;
    wait_idle("post_rst");
    repeat (3) @(negedge clk);

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the detector.
REQ-002 Parameter WIDTH, default 8: bits per submitted word.
REQ-003 Ports:
- clk  in  1: the single clock; all state updates on its rising edge.
- rst  in  1: reset; asynchronous, active-high.
- req  in  NREQ: per-requester request, level.
- data  in  NREQ*WIDTH: requester i word at bits [i*WIDTH +: WIDTH].
- gnt  out  NREQ: one-hot grant, one-cycle pulse.
- busy  out  1: high in every cycle the controller is not IDLE.
- done  out  1: one-cycle pulse; the result is valid.
- done_id  out  clog2(NREQ): index of the requester that was served.
- match_cnt  out  clog2(WIDTH)+1: number of "1011" detections in the word.

Function
REQ-004 The controller FSM SHALL have the states IDLE, SHIFT, FLUSH and DONE.
REQ-005 In IDLE with any req bit high, at the clock edge the controller SHALL:
- pick the winner by round robin, starting from (last_grant+1) mod NREQ;
- latch that requester's data word and clear the bit counter and match counter;
- reset the detector to state A, and enter SHIFT.
REQ-006 gnt SHALL be high only in the first SHIFT cycle, at the winner's bit; last_grant SHALL update to the winner.
REQ-007 SHIFT SHALL last exactly WIDTH cycles and feed one bit per cycle into the detector, MSB first.
REQ-008 FLUSH SHALL last 1 cycle so the final Moore output is captured.
REQ-009 DONE SHALL last 1 cycle with done=1 and valid done_id and match_cnt, then return to IDLE.
REQ-010 done SHALL therefore assert WIDTH+1 cycles after gnt; no new grant is possible before the cycle after DONE.
REQ-011 match_cnt SHALL increment in every SHIFT (except the first) or FLUSH cycle in which the detector is in state E.
REQ-012 match_cnt and done_id SHALL hold their values until the next DONE.
REQ-013 The detector SHALL be a 5-state Moore machine for "1011" with detect = (state==E):
- A: 0->A, 1->B
- B: 0->C, 1->B
- C: 0->A, 1->D
- D: 0->C, 1->E
- E: see REQ-025
REQ-014 req changes while busy SHALL be ignored; data is sampled only at the grant edge.
REQ-015 A req dropped before it is granted SHALL NOT be served.
REQ-016 A single active requester SHALL be granted back-to-back with no starvation penalty.

Reset
REQ-017 On rst, asynchronously:
- FSM SHALL go to IDLE and the detector to A;
- gnt, busy, done and match_cnt SHALL be 0;
- done_id SHALL be 0;
- last_grant SHALL be NREQ-1, so that req[0] has first priority.
REQ-018 Reset asserted mid-SHIFT SHALL abort the word with no done pulse; the word is not re-served unless it is requested again.

Configuration
REQ-019 The macro SEQ_DET_OVERLAP_EN SHALL select overlapping detection.
REQ-020 With SEQ_DET_OVERLAP_EN defined: E on 0->C, E on 1->B.
REQ-021 Without SEQ_DET_OVERLAP_EN: E on 0->A, E on 1->B (non-overlapping).

Structure
REQ-022 Package seq_det_pkg SHALL hold:
- the controller state enum (IDLE, SHIFT, FLUSH, DONE);
- the detector state enum (A=3'b000, B=3'b001, C=3'b010, D=3'b011, E=3'b100);
- NREQ and WIDTH defaults.
REQ-023 The detector SHALL be the sub-module seq_det_core. Its ports are clk, rst, clr, en, x and det; it is instantiated once.
REQ-024 Round-robin selection and the controller FSM SHALL stay in seq_det_sched.
REQ-025 seq_det_core SHALL implement the E-state transitions of REQ-020/REQ-021. clr SHALL force state A synchronously, and en=0 SHALL hold the state.

Verification
REQ-026 req=4'b0001, data[7:0]=8'b10110110: with SEQ_DET_OVERLAP_EN -> done_id=0, match_cnt=2; without it -> match_cnt=1.
REQ-027 req=4'b0100, word 8'hBB -> match_cnt=2 in both modes; word 8'hFF -> match_cnt=0.
REQ-028 req=4'b1111 held -> grant order 0,1,2,3,0. Each gnt comes 10 cycles after the previous one when WIDTH=8.
REQ-029 gnt at cycle t -> busy high from t through t+9, done high only in cycle t+9, gnt not asserted again before t+10.
REQ-030 Assert rst during the 4th SHIFT cycle with req=4'b0010 -> all outputs 0 immediately. After release with req=4'b0011 -> first grant goes to req[0].
